// File: rtl/booth_r4_pkg.sv
// Shared types and the radix-4 Booth recoding table for the sequential multiplier.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    DigZero,
    DigPos1,
    DigPos2,
    DigNeg1,
    DigNeg2
  } digit_e;

  // Group is {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_e booth_digit(input logic [2:0] group);
    digit_e dig;
    unique case (group)
      3'b000, 3'b111: dig = DigZero;
      3'b001, 3'b010: dig = DigPos1;
      3'b011:         dig = DigPos2;
      3'b100:         dig = DigNeg2;
      3'b101, 3'b110: dig = DigNeg1;
      default:        dig = DigZero;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Combinational Booth digit encoder: turns a 3-bit multiplier group into a partial-product
// magnitude plus a negate flag that the accumulator uses as its carry-in.
module booth_r4_digit_enc
  import booth_r4_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [2:0]   group_i,
  input  logic [W-1:0] a_i,
  output logic [W:0]   pp_op_o,
  output logic         pp_neg_o
);

  digit_e digit;

  always_comb begin
    digit    = booth_digit(group_i);
    pp_op_o  = '0;
    pp_neg_o = 1'b0;
    unique case (digit)
      DigPos1: pp_op_o = {a_i[W-1], a_i};
      DigPos2: pp_op_o = {a_i, 1'b0};
      DigNeg1: begin
        pp_op_o  = {a_i[W-1], a_i};
        pp_neg_o = 1'b1;
      end
      DigNeg2: begin
        pp_op_o  = {a_i, 1'b0};
        pp_neg_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Define BOOTH_UNSIGNED_EN to add the in_signed port and an unsigned mode (one extra digit).
module booth_r4_seq_mult
  import booth_r4_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           in_signed,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic [W:0]     pp_op,
  output logic           pp_neg
);

  localparam int unsigned NDIG = W / 2;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned CW   = $clog2(NDIG + 2);
`ifdef BOOTH_UNSIGNED_EN
  // One extra bit on A keeps +-2A exact for zero-extended operands.
  localparam int unsigned AW = W + 1;
  localparam int unsigned BW = W + 2;
`else
  localparam int unsigned AW = W;
  localparam int unsigned BW = W;
`endif

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [PW-1:0]   out_p_q;
  logic [PW-1:0]   acc_q;
  logic [AW-1:0]   a_q;
  logic [BW-1:0]   b_q;
  logic            b_prev_q;
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [CW-1:0]   last_cnt;
  logic [AW:0]     enc_op;
  logic            enc_neg;
  logic [AW:0]     pp_x;
  logic [PW-1:0]   pp_ext;
  logic [PW-1:0]   acc_sum;

`ifdef BOOTH_UNSIGNED_EN
  logic signed_q;

  always_comb begin
    a_ext    = in_signed ? {in_a[W-1], in_a} : {1'b0, in_a};
    b_ext    = in_signed ? {{2{in_b[W-1]}}, in_b} : {2'b00, in_b};
    last_cnt = signed_q ? CW'(NDIG - 1) : CW'(NDIG);
  end
`else
  always_comb begin
    a_ext    = in_a;
    b_ext    = in_b;
    last_cnt = CW'(NDIG - 1);
  end
`endif

  // b_q shifts right two bits per digit, so the current group always sits at the bottom.
  booth_r4_digit_enc #(
    .W (AW)
  ) u_digit_enc (
    .group_i  ({b_q[1], b_q[0], b_prev_q}),
    .a_i      (a_q),
    .pp_op_o  (enc_op),
    .pp_neg_o (enc_neg)
  );

  always_comb begin
    pp_x    = enc_op ^ {(AW + 1){enc_neg}};
    pp_ext  = PW'($signed(pp_x));
    acc_sum = acc_q + ((pp_ext + PW'(enc_neg)) << {cnt_q, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      b_prev_q    <= 1'b0;
      cnt_q       <= '0;
`ifdef BOOTH_UNSIGNED_EN
      signed_q    <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            state_q    <= StCalc;
            in_ready_q <= 1'b0;
            a_q        <= a_ext;
            b_q        <= b_ext;
            b_prev_q   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
`ifdef BOOTH_UNSIGNED_EN
            signed_q   <= in_signed;
`endif
          end
        end
        StCalc: begin
          acc_q    <= acc_sum;
          b_q      <= b_q >> 2;
          b_prev_q <= b_q[1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == last_cnt) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_p_q     <= acc_sum;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign pp_op     = (state_q == StCalc) ? enc_op[W:0] : '0;
  assign pp_neg    = (state_q == StCalc) & enc_neg;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed bench for booth_r4_seq_mult (W=8): latency, digit observe ports, backpressure,
// mid-operation reset; unsigned mode is exercised when BOOTH_UNSIGNED_EN is defined.
module tb_booth_r4_seq_mult;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic [W:0]     pp_op;
  logic           pp_neg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_r4_seq_mult #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef BOOTH_UNSIGNED_EN
    .in_signed (in_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .pp_op     (pp_op),
    .pp_neg    (pp_neg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offers one operand pair for a single edge; returns at the negedge after acceptance.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_pp_op", pp_op, 0);
    check("rst_pp_neg", pp_neg, 0);
    rst_n = 1'b1;
    tick();

    // 3 * 5: digits +A, +A, 0, 0
    out_ready = 1'b1;
    offer(8'd3, 8'd5);
    check("t1_in_ready_busy", in_ready, 0);
    check("t1_d0_pp_op", pp_op, 9'h003);
    check("t1_d0_pp_neg", pp_neg, 0);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid_early", out_valid, 0);
      tick();
    end
    check("t1_valid", out_valid, 1);
    check("t1_out_p", out_p, 16'h000F);
    tick();
    check("t1_valid_after", out_valid, 0);
    check("t1_ready_after", in_ready, 1);
    check("t1_p_kept", out_p, 16'h000F);

    // -128 * -128: top digit is 100 -> -2A needing 9 bits
    offer(8'h80, 8'h80);
    tick();
    tick();
    tick();
    check("t2_d3_pp_op", pp_op, 9'h100);
    check("t2_d3_pp_neg", pp_neg, 1);
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_out_p", out_p, 16'h4000);
    tick();

    // 127 * -1: digit 0 is -A, upper digits are zero with no negate
    offer(8'd127, 8'hFF);
    check("t3_d0_pp_op", pp_op, 9'h07F);
    check("t3_d0_pp_neg", pp_neg, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t3_dz_pp_op", pp_op, 0);
      check("t3_dz_pp_neg", pp_neg, 0);
    end
    tick();
    check("t3_valid", out_valid, 1);
    check("t3_out_p", out_p, 16'hFF81);
    tick();

    // -128 * 127 with backpressure and an ignored offer while busy
    out_ready = 1'b0;
    offer(8'h80, 8'd127);
    for (int k = 0; k < 4; k++) tick();
    check("t4_valid", out_valid, 1);
    check("t4_out_p", out_p, 16'hC080);
    in_valid = 1'b1;
    in_a     = 8'h11;
    in_b     = 8'h22;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_p", out_p, 16'hC080);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_pp_op", pp_op, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t4_hs_valid", out_valid, 0);
    check("t4_hs_in_ready", in_ready, 1);
    check("t4_hs_p", out_p, 16'hC080);
    tick();
    check("t4_idle_in_ready", in_ready, 1);
    check("t4_idle_valid", out_valid, 0);

    // Reset at CALC cycle 2 discards 5 * 7
    offer(8'd5, 8'd7);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_pp_op", pp_op, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_no_valid", out_valid, 0);
    end
    offer(8'd2, 8'hFD);
    for (int k = 0; k < 4; k++) tick();
    check("t5_valid", out_valid, 1);
    check("t5_out_p", out_p, 16'hFFFA);
    tick();

`ifdef BOOTH_UNSIGNED_EN
    in_signed = 1'b0;
    offer(8'hFF, 8'hFF);
    for (int k = 0; k < 4; k++) tick();
    check("t6u_valid_early", out_valid, 0);
    tick();
    check("t6u_valid", out_valid, 1);
    check("t6u_out_p", out_p, 16'hFE01);
    tick();
    in_signed = 1'b1;
    offer(8'hFF, 8'hFF);
    for (int k = 0; k < 4; k++) tick();
    check("t6s_valid", out_valid, 1);
    check("t6s_out_p", out_p, 16'h0001);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
